// File: rtl/sram_1w1r_init_front.sv
// Front end for a 1w1r SRAM macro: sweeps INIT_VALUE into every entry after reset/flush,
// then passes client traffic through and forwards write data on same-address read/write.
module sram_1w1r_init_front #(
    parameter int                ADDR_W     = 7,
    parameter int                DEPTH      = 128,
    parameter int                DATA_W     = 44,
    parameter int                MASK_W     = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    output logic              ready,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [MASK_W-1:0] w_mask,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic              W0_en,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data,
    output logic [MASK_W-1:0] W0_mask,
    output logic              R0_en,
    output logic [ADDR_W-1:0] R0_addr,
    input  logic [DATA_W-1:0] R0_data
);

    localparam int                LW   = DATA_W / MASK_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    logic              run_p0;
    logic              hit_p0;
    logic              vld_p1;
    logic              fwd_hit_p1;
    logic [DATA_W-1:0] fwd_data_p1;
    logic [MASK_W-1:0] fwd_mask_p1;

    // Lanes enabled in the forwarded write come from the write data, the rest from the macro.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] fwd,
        input logic [MASK_W-1:0] mask,
        input logic [DATA_W-1:0] mem
    );
        logic [DATA_W-1:0] res;
        res = mem;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                res[i*LW +: LW] = fwd[i*LW +: LW];
            end
        end
        return res;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        W0_en     = 1'b0;
        W0_addr   = '0;
        W0_data   = '0;
        W0_mask   = '0;
        R0_en     = 1'b0;
        R0_addr   = '0;
        unique case (state)
            IDLE: begin
                state_nxt = INIT;
            end
            INIT: begin
                W0_en   = 1'b1;
                W0_addr = cnt;
                W0_data = INIT_VALUE;
                W0_mask = '1;
                if (flush) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                ready   = 1'b1;
                W0_en   = w_en;
                W0_addr = w_addr;
                W0_data = w_data;
                W0_mask = w_mask;
                R0_en   = r_en;
                R0_addr = r_addr;
                if (flush) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // p0: client request cycle, collision detect
    assign run_p0 = (state == RUN);
    assign hit_p0 = run_p0 & r_en & w_en & (r_addr == w_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            fwd_hit_p1  <= 1'b0;
            fwd_data_p1 <= '0;
            fwd_mask_p1 <= '0;
        end else begin
            vld_p1     <= run_p0 & r_en;
            fwd_hit_p1 <= hit_p0;
            if (hit_p0) begin
                fwd_data_p1 <= w_data;
                fwd_mask_p1 <= w_mask;
            end
        end
    end

    // p1: macro data returns, merged with forwarded lanes
    assign r_valid = vld_p1;
    assign r_data  = fwd_hit_p1 ? merge_lanes(fwd_data_p1, fwd_mask_p1, R0_data) : R0_data;

endmodule

// File: tb/tb_sram_1w1r_init_front.sv
// Bench for sram_1w1r_init_front: behavioural macro model, read scoreboard, vector table
// and hand-written reset/flush sequences; a second DEPTH=40 instance covers the non-power-of-two sweep.
module tb_sram_1w1r_init_front;

    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int DW    = 44;
    localparam int MW    = 4;
    localparam int LW    = DW / MW;
    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          ready;
    logic          w_en = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [MW-1:0] w_mask = '0;
    logic          r_en = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          W0_en;
    logic [AW-1:0] W0_addr;
    logic [DW-1:0] W0_data;
    logic [MW-1:0] W0_mask;
    logic          R0_en;
    logic [AW-1:0] R0_addr;
    logic [DW-1:0] R0_data = '0;

    logic          flush40 = 1'b0;
    logic          ready40;
    logic          w_en40 = 1'b0;
    logic [5:0]    w_addr40 = '0;
    logic [DW-1:0] w_data40 = '0;
    logic [MW-1:0] w_mask40 = '0;
    logic          r_en40 = 1'b0;
    logic [5:0]    r_addr40 = '0;
    logic          r_valid40;
    logic [DW-1:0] r_data40;
    logic          W0_en40;
    logic [5:0]    W0_addr40;
    logic [DW-1:0] W0_data40;
    logic [MW-1:0] W0_mask40;
    logic          R0_en40;
    logic [5:0]    R0_addr40;
    logic [DW-1:0] R0_data40 = '0;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[DEPTH];

    sram_1w1r_init_front #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .MASK_W(MW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ready(ready),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid), .r_data(r_data),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data)
    );

    sram_1w1r_init_front #(.ADDR_W(6), .DEPTH(40), .DATA_W(DW), .MASK_W(MW)) dut40 (
        .clock(clock), .reset(reset), .flush(flush40), .ready(ready40),
        .w_en(w_en40), .w_addr(w_addr40), .w_data(w_data40), .w_mask(w_mask40),
        .r_en(r_en40), .r_addr(r_addr40), .r_valid(r_valid40), .r_data(r_data40),
        .W0_en(W0_en40), .W0_addr(W0_addr40), .W0_data(W0_data40), .W0_mask(W0_mask40),
        .R0_en(R0_en40), .R0_addr(R0_addr40), .R0_data(R0_data40)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] lane_write(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                                 input logic [MW-1:0] m);
        logic [DW-1:0] res;
        res = old;
        for (int i = 0; i < MW; i++) if (m[i]) res[i*LW +: LW] = d[i*LW +: LW];
        return res;
    endfunction

    // Macro model: read-before-write, one cycle read latency.
    always @(posedge clock) begin
        if (W0_en) mem[W0_addr] <= lane_write(mem[W0_addr], W0_data, W0_mask);
        if (R0_en) R0_data <= mem[R0_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && r_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(r_data), 64'hDEAD);
            end else begin
                check("r_data", 64'(r_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // Samples just after each edge n (n=0 is the first edge after release); ready seen
    // after edge DEPTH is what a registered consumer captures at edge DEPTH+1.
    task automatic sweep_check(input bit poke);
        int bad = 0, wr = 0, first = -1;
        int bad40 = 0, wr40 = 0, first40 = -1;
        for (int n = 0; n < DEPTH + 8; n++) begin
            @(posedge clock); #1;
            if (W0_en) begin
                if (W0_addr != AW'(wr) || W0_data != '0 || W0_mask != 4'hF) bad++;
                wr++;
            end
            if (R0_en || r_valid) bad++;
            if (ready && first < 0) first = n;
            if (!ready && first >= 0) bad++;
            if (W0_en40) begin
                if (W0_addr40 != 6'(wr40) || int'(W0_addr40) >= 40) bad40++;
                wr40++;
            end
            if (ready40 && first40 < 0) first40 = n;
            if (poke && n == 10) begin
                w_en = 1'b1; w_addr = 7'd5; w_data = 44'hABC; w_mask = 4'hF;
                r_en = 1'b1; r_addr = 7'd5;
            end else begin
                w_en = 1'b0; r_en = 1'b0;
            end
        end
        check("sweep_writes", 64'(wr), 64'(DEPTH));
        check("sweep_order", 64'(bad), 64'd0);
        check("ready_edge", 64'(first), 64'(DEPTH));
        check("sweep40_writes", 64'(wr40), 64'd40);
        check("sweep40_range", 64'(bad40), 64'd0);
        check("ready40_edge", 64'(first40), 64'd40);
    endtask

    typedef struct {
        logic          w_en;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic [MW-1:0] w_mask;
        logic          r_en;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int low;
        int addr_after;
        for (int i = 0; i < DEPTH; i++) mem[i] = 44'h0AA_AAAA_AAAA ^ DW'(i);

        // Lane 0 = [10:0], lane 1 = [21:11], lane 2 = [32:22], lane 3 = [43:33].
        vecs[0] = '{1'b1, 7'd3,   ALL1,    4'hF,    1'b1, 7'd5,   44'h0};
        vecs[1] = '{1'b1, 7'd10,  44'h123, 4'hF,    1'b1, 7'd3,   ALL1};
        vecs[2] = '{1'b1, 7'd3,   44'h0,   4'b0101, 1'b1, 7'd3,   44'hFFE_003F_F800};
        vecs[3] = '{1'b1, 7'd3,   ALL1,    4'b0000, 1'b1, 7'd3,   44'hFFE_003F_F800};
        vecs[4] = '{1'b0, 7'd0,   44'h0,   4'h0,    1'b1, 7'd10,  44'h123};
        vecs[5] = '{1'b1, 7'd127, ALL1,    4'b1000, 1'b1, 7'd127, 44'hFFE_0000_0000};
        vecs[6] = '{1'b0, 7'd0,   44'h0,   4'h0,    1'b1, 7'd127, 44'hFFE_0000_0000};
        vecs[7] = '{1'b0, 7'd0,   44'h0,   4'h0,    1'b1, 7'd0,   44'h0};
        vecs[8] = '{1'b0, 7'd0,   44'h0,   4'h0,    1'b0, 7'd0,   44'h0};

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_w0", 64'({W0_en, W0_addr, W0_mask}), 64'd0);
        check("rst_w0_data", 64'(W0_data), 64'd0);
        check("rst_r0_en", 64'(R0_en), 64'd0);
        check("rst_rvalid", 64'(r_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        sweep_check(1'b1);

        for (int i = 0; i < 9; i++) begin
            w_en = vecs[i].w_en; w_addr = vecs[i].w_addr; w_data = vecs[i].w_data; w_mask = vecs[i].w_mask;
            r_en = vecs[i].r_en; r_addr = vecs[i].r_addr;
            if (vecs[i].r_en) exp_q.push_back(vecs[i].exp);
            #1;
            check("run_ready", 64'(ready), 64'd1);
            check("w_pass", 64'({W0_en, W0_addr, W0_mask, W0_data}), 64'({w_en, w_addr, w_mask, w_data}));
            check("r_pass", 64'({R0_en, R0_addr}), 64'({r_en, r_addr}));
            @(posedge clock); #1;
            check("r_valid", 64'(r_valid), 64'(vecs[i].r_en));
        end
        w_en = 1'b0; r_en = 1'b0;

        // Flush from RUN with a read in the same cycle.
        w_en = 1'b1; w_addr = 7'd7; w_data = 44'h777; w_mask = 4'hF;
        @(posedge clock); #1;
        w_en = 1'b0;
        flush = 1'b1; r_en = 1'b1; r_addr = 7'd7;
        exp_q.push_back(44'h777);
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_rvalid", 64'(r_valid), 64'd1);
        check("flush_ready_drop", 64'(ready), 64'd0);
        low = 0;
        for (int k = 0; k < DEPTH + 8 && !ready; k++) begin
            low++;
            @(posedge clock); #1;
        end
        check("flush_low_cycles", 64'(low), 64'(DEPTH));
        exp_q.push_back(44'h0);
        @(posedge clock); #1;
        r_en = 1'b0;
        check("post_flush_rvalid", 64'(r_valid), 64'd1);

        // Flush during INIT restarts the sweep.
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        low = 0;
        addr_after = -1;
        for (int k = 0; k < 2 * DEPTH && !ready; k++) begin
            if (k == 21) addr_after = int'(W0_addr);
            low++;
            flush = (k == 20);
            @(posedge clock); #1;
        end
        flush = 1'b0;
        check("init_flush_addr", 64'(addr_after), 64'd0);
        check("init_flush_len", 64'(low), 64'(21 + DEPTH));

        // Reset with a read outstanding clears r_valid.
        r_en = 1'b1; r_addr = 7'd0;
        @(posedge clock); #1;
        r_en = 1'b0;
        check("pre_reset_rvalid", 64'(r_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_rvalid_clr", 64'(r_valid), 64'd0);
        check("reset_run_ready", 64'(ready), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sweep_check(1'b0);

        // Reset in the middle of a sweep.
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        for (int k = 0; k < DEPTH && W0_addr != 7'd50; k++) begin
            @(posedge clock); #1;
        end
        check("reach_cnt50", 64'(W0_addr), 64'd50);
        reset = 1'b1;
        #1;
        check("mid_reset_w0_en", 64'(W0_en), 64'd0);
        check("mid_reset_ready", 64'(ready), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sweep_check(1'b0);

        @(posedge clock); #1;
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
